// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single-ported vector data memory between the
// pipeline MEM stage (port P, default priority) and an external host port (H).
// Ports:
//   clk, rst                          - clock, asynchronous active-low reset
//   p_req/p_we/p_addr/p_wdata         - pipeline access request
//   p_gnt, p_stall                    - pipeline grant / lost-arbitration stall (combinational)
//   p_rvalid/p_rdata                  - pipeline read return, one cycle after a granted read
//   h_req/h_we/h_lock/h_addr/h_wdata  - host access request, h_lock holds a burst
//   h_gnt, h_rvalid/h_rdata           - host grant and read return
//   m_en/m_we/m_addr/m_wdata/m_rdata  - data RAM port, read data valid one cycle after access
module data_mem_arbiter #(
   parameter  int RW         = 24,
   parameter  int N          = 6,
   parameter  int AW         = 24,
   parameter  int STARVE_MAX = 4,
   parameter  int BURST_MAX  = 8,
   localparam int DW         = RW * N
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          p_req,
   input  logic          p_we,
   input  logic [AW-1:0] p_addr,
   input  logic [DW-1:0] p_wdata,
   output logic          p_gnt,
   output logic          p_stall,
   output logic          p_rvalid,
   output logic [DW-1:0] p_rdata,
   input  logic          h_req,
   input  logic          h_we,
   input  logic          h_lock,
   input  logic [AW-1:0] h_addr,
   input  logic [DW-1:0] h_wdata,
   output logic          h_gnt,
   output logic          h_rvalid,
   output logic [DW-1:0] h_rdata,
   output logic          m_en,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata
);
   typedef enum logic [1:0] {PRI_P, FORCE_H, BURST} arbState;
   typedef enum logic [1:0] {NONE, OWN_P, OWN_H} rdOwnerT;
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
   localparam logic [7:0] BURST_LIM  = 8'(BURST_MAX);
   arbState state, stateNext, priState;
   rdOwnerT rdOwner;
   logic [3:0] waitCnt, waitNext, priWait;
   logic [7:0] burstCnt, burstNext, priBurst;
   logic [DW-1:0] pHold, hHold;
   logic gntP, gntH, priGntP, priGntH;
   always_comb begin
      // pipeline-priority rule set; FORCE_H and BURST fall back to it when the host lets go
      priGntP   = p_req;
      priGntH   = !p_req && h_req;
      priWait   = (p_req && h_req) ? waitCnt + 4'd1 : 4'd0;
      priBurst  = (priGntH && h_lock) ? 8'd1 : 8'd0;
      priState  = (priWait >= STARVE_LIM) ? FORCE_H : (priGntH && h_lock) ? BURST : PRI_P;
      gntP      = priGntP;
      gntH      = priGntH;
      waitNext  = priWait;
      burstNext = priBurst;
      stateNext = priState;
      if (state == FORCE_H && h_req) begin
         gntP      = 1'b0;
         gntH      = 1'b1;
         waitNext  = 4'd0;
         burstNext = h_lock ? 8'd1 : 8'd0;
         stateNext = h_lock ? BURST : PRI_P;
      end else if (state == BURST && h_req && h_lock) begin
         if (burstCnt < BURST_LIM || !p_req) begin
            gntP      = 1'b0;
            gntH      = 1'b1;
            waitNext  = waitCnt;
            burstNext = (burstCnt < BURST_LIM) ? burstCnt + 8'd1 : burstCnt;
            stateNext = BURST;
         end else begin
            // burst exhausted with P waiting: P wins and this cycle already counts as a host loss
            gntP      = 1'b1;
            gntH      = 1'b0;
            waitNext  = 4'd1;
            burstNext = 8'd0;
            stateNext = PRI_P;
         end
      end
   end
   // grants are forced low while reset is held so the RAM sees no access
   assign p_gnt    = rst & gntP;
   assign h_gnt    = rst & gntH;
   assign p_stall  = rst & p_req & ~gntP;
   assign m_en     = p_gnt | h_gnt;
   assign m_we     = (p_gnt & p_we) | (h_gnt & h_we);
   assign m_addr   = p_gnt ? p_addr : h_gnt ? h_addr : '0;
   assign m_wdata  = p_gnt ? p_wdata : h_gnt ? h_wdata : '0;
   assign p_rvalid = rdOwner == OWN_P;
   assign h_rvalid = rdOwner == OWN_H;
   assign p_rdata  = p_rvalid ? m_rdata : pHold;
   assign h_rdata  = h_rvalid ? m_rdata : hHold;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= PRI_P;
         waitCnt  <= 4'd0;
         burstCnt <= 8'd0;
         rdOwner  <= NONE;
         pHold    <= '0;
         hHold    <= '0;
      end else begin
         state    <= stateNext;
         waitCnt  <= waitNext;
         burstCnt <= burstNext;
         rdOwner  <= (gntP && !p_we) ? OWN_P : (gntH && !h_we) ? OWN_H : NONE;
         if (rdOwner == OWN_P) pHold <= m_rdata;
         if (rdOwner == OWN_H) hHold <= m_rdata;
      end
   end
endmodule
